// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter and its round-robin
// grant helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic port_id_t;

    localparam int DEF_MEM_LAT = 1;
    localparam int DEF_WORDS   = 2048;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant: a lone requester wins; on a tie the port
// that was not served last wins.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  port_id_t   i_last,
    output port_id_t   o_gnt_id,
    output logic       o_any
);

    always_comb begin
        o_any    = |i_req;
        o_gnt_id = 1'b0;
        if (i_req == 2'b11) begin
            o_gnt_id = ~i_last;
        end else if (i_req[1]) begin
            o_gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises port 0 (MEM stage) and port 1 (loader/debug) onto the single-port
// data memory: one access at a time, fixed latency, done pulse with read data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int WORDS   = DEF_WORDS,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_done,
    output logic              o_m0_err,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_done,
    output logic              o_m1_err,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    localparam int                CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-3:0] WORDS_LIM = (ADDR_W-2)'(WORDS);

    state_t              r_state;
    state_t              w_state_next;
    port_id_t            r_last;
    port_id_t            r_id;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic                r_oor;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                r_m0_err;
    logic                r_m1_err;

    port_id_t            w_gnt_id;
    logic                w_any;
    logic                w_win_we;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_win_oor;
    logic                w_cnt_last;
    logic [DATA_W-1:0]   w_cap_data;

    rr_arbiter2 u_arb (
        .i_req    ({i_m1_req, i_m0_req}),
        .i_last   (r_last),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    assign w_win_we    = w_gnt_id ? i_m1_we    : i_m0_we;
    assign w_win_addr  = w_gnt_id ? i_m1_addr  : i_m0_addr;
    assign w_win_wdata = w_gnt_id ? i_m1_wdata : i_m0_wdata;
    assign w_win_oor   = (w_win_addr[ADDR_W-1:2] >= WORDS_LIM);
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    // Writes and out-of-range accesses return zero, never the bus contents.
    assign w_cap_data  = (r_we || r_oor) ? '0 : i_mem_rdata;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = ACCESS;
            ACCESS:  if (w_cnt_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_oor      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_err   <= 1'b0;
            r_m1_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_gnt_id;
                        r_we    <= w_win_we;
                        r_addr  <= w_win_addr;
                        r_wdata <= w_win_wdata;
                        r_oor   <= w_win_oor;
                        r_cnt   <= '0;
                    end
                end
                ACCESS: begin
                    if (!w_cnt_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_id) begin
                        r_m1_rdata <= w_cap_data;
                        r_m1_err   <= r_oor;
                    end else begin
                        r_m0_rdata <= w_cap_data;
                        r_m0_err   <= r_oor;
                    end
                end
                DONE:    r_last <= r_id;
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_mem_rd    = (r_state == ACCESS) && !r_we && !r_oor;
    assign o_mem_wr    = (r_state == ACCESS) &&  r_we && !r_oor;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

    assign o_m0_done   = (r_state == DONE) && (r_id == 1'b0);
    assign o_m1_done   = (r_state == DONE) && (r_id == 1'b1);
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;
    assign o_m0_err    = r_m0_err;
    assign o_m1_err    = r_m1_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner-case
// sequences, then randomized two-port traffic against a behavioural memory model.
module tb_dmem_arbiter;

    localparam int LAT     = 3;
    localparam int NWORDS  = 2048;
    localparam int TIMEOUT = 40;
    localparam int NRAND   = 30;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        o_m0_done, o_m0_err, o_m1_done, o_m1_err;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_mem_rd, o_mem_wr, o_busy;
    logic [31:0] o_mem_addr, o_mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WORDS(NWORDS), .MEM_LAT(LAT)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_done(o_m0_done), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_done(o_m1_done), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
        .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(o_busy)
    );

    function automatic logic [31:0] init_pat(input int i);
        return 32'hC0DE_0000 ^ 32'(i);
    endfunction

    // Data memory seen by the DUT: writes on every negedge while WR is high.
    logic [31:0] tb_mem [0:NWORDS-1];
    bit          tb_written [0:NWORDS-1];
    logic [10:0] mem_idx;
    assign mem_idx   = o_mem_addr[12:2];
    assign mem_rdata = !o_mem_rd ? 32'h5A5A_5A5A :
                       (tb_written[mem_idx] ? tb_mem[mem_idx] : init_pat(int'(mem_idx)));

    int          cnt_busy = 0, cnt_rd = 0, cnt_wr = 0;
    logic [31:0] last_addr = '0;
    always @(negedge clk) begin
        if (o_mem_wr) begin
            tb_mem[mem_idx]     <= o_mem_wdata;
            tb_written[mem_idx] <= 1'b1;
        end
        if (o_busy)   cnt_busy <= cnt_busy + 1;
        if (o_mem_rd) cnt_rd   <= cnt_rd + 1;
        if (o_mem_wr) cnt_wr   <= cnt_wr + 1;
        if (o_mem_rd || o_mem_wr) last_addr <= o_mem_addr;
    end

    // Reference contents: updated only when a write completes in range.
    logic [31:0] model_mem [0:NWORDS-1];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input bit p, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd,
                          output bit er, output int lat);
        bit seen;
        seen = 1'b0; lat = 0; rd = '0; er = 1'b0;
        tick();
        if (!p) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        while (!seen && lat < TIMEOUT) begin
            tick();
            lat++;
            if (p ? o_m1_done : o_m0_done) begin
                seen = 1'b1;
                rd   = p ? o_m1_rdata : o_m0_rdata;
                er   = p ? o_m1_err : o_m0_err;
            end
        end
        if (!p) m0_req = 1'b0; else m1_req = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL txn_timeout port=%0d actual=no_done required=done", p);
        end
    endtask

    task automatic apply_reset();
        m0_req = 1'b0; m1_req = 1'b0;
        i_reset = 1'b0;
        tick(); tick();
        i_reset = 1'b1;
    endtask

    task automatic rand_txn(input bit p);
        bit          we, oor, er;
        int          word, lat;
        logic [31:0] addr, wdata, rd, exp_rd;
        repeat ($urandom_range(0, 2)) tick();
        we    = 1'($urandom_range(0, 1));
        oor   = ($urandom_range(0, 7) == 0);
        word  = oor ? NWORDS + int'($urandom_range(0, 100)) : int'($urandom_range(0, 15));
        addr  = {word[29:0], 2'($urandom_range(0, 3))};
        wdata = $urandom;
        do_txn(p, we, addr, wdata, rd, er, lat);
        exp_rd = (we || oor) ? 32'h0 : model_mem[word];
        if (!oor && we) model_mem[word] = wdata;
        $display("rand p%0d we=%0d addr=%08h rdata=%08h err=%0d lat=%0d", p, we, addr, rd, er, lat);
        chk("rand_rdata", 64'(rd), 64'(exp_rd));
        chk("rand_err", 64'(er), 64'(oor));
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin : main
        logic [31:0] rd, other_before;
        bit          er, f0, f1;
        int          lat, b0, r0, w0, order[$], exp_alt[4], first, guard, ov0, ov1;

        for (int i = 0; i < NWORDS; i++) model_mem[i] = init_pat(i);

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0017, 32'h0,         32'h1234_5678, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         32'h0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_2000, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_1FFC, 32'h0,         init_pat(2047), 1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         init_pat(0), 1'b0};

        // Reset state
        tick(); tick();
        chk("reset_busy_rd_wr", {o_busy, o_mem_rd, o_mem_wr}, 3'b000);
        chk("reset_done_err", {o_m0_done, o_m1_done, o_m0_err, o_m1_err}, 4'b0000);
        chk("reset_mem_addr", 64'(o_mem_addr), 64'h0);
        chk("reset_rdata", {o_m0_rdata, o_m1_rdata}, 64'h0);
        i_reset = 1'b1;

        // Directed vectors, one port at a time
        for (int i = 0; i < 10; i++) begin
            other_before = vecs[i].port ? o_m0_rdata : o_m1_rdata;
            b0 = cnt_busy; r0 = cnt_rd; w0 = cnt_wr;
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            if (vecs[i].we && !vecs[i].exp_err) model_mem[vecs[i].addr[12:2]] = vecs[i].wdata;
            $display("vec %0d p%0d we=%0d addr=%08h rdata=%08h err=%0d lat=%0d",
                     i, vecs[i].port, vecs[i].we, vecs[i].addr, rd, er, lat);
            chk("vec_rdata", 64'(rd), 64'(vecs[i].exp_rdata));
            chk("vec_err", 64'(er), 64'(vecs[i].exp_err));
            chk("vec_latency", 64'(lat), 64'(LAT + 1));
            chk("vec_busy_cycles", 64'(cnt_busy - b0), 64'(LAT + 1));
            chk("vec_wr_cycles", 64'(cnt_wr - w0),
                64'((vecs[i].we && !vecs[i].exp_err) ? LAT : 0));
            chk("vec_rd_cycles", 64'(cnt_rd - r0),
                64'((!vecs[i].we && !vecs[i].exp_err) ? LAT : 0));
            if (!vecs[i].exp_err) chk("vec_mem_addr", 64'(last_addr), 64'(vecs[i].addr));
            chk("vec_other_rdata", 64'(vecs[i].port ? o_m0_rdata : o_m1_rdata), 64'(other_before));
        end

        // Tie straight after reset, then continuous requests on both ports
        apply_reset();
        m0_we = 1'b0; m0_addr = 32'h20; m1_we = 1'b0; m1_addr = 32'h24;
        m0_req = 1'b1; m1_req = 1'b1;
        order.delete();
        for (int t = 0; t < 60 && order.size() < 4; t++) begin
            tick();
            if (o_m0_done) begin
                order.push_back(0);
                chk("alt_rdata0", 64'(o_m0_rdata), 64'(model_mem[8]));
            end else if (o_m1_done) begin
                order.push_back(1);
                chk("alt_rdata1", 64'(o_m1_rdata), 64'(model_mem[9]));
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        exp_alt = '{0, 1, 0, 1};
        chk("alt_count", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            $display("alt grant %0d port=%0d", i, order[i]);
            chk("alt_order", 64'(order[i]), 64'(exp_alt[i]));
        end
        tick(); tick();

        // Port 0 drops req during ACCESS: access still completes, nothing re-issued
        r0 = cnt_rd;
        m0_we = 1'b0; m0_addr = 32'h10; m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        lat = 1;
        while (!o_m0_done && lat < TIMEOUT) begin tick(); lat++; end
        $display("drop_req done=%0d rdata=%08h lat=%0d", o_m0_done, o_m0_rdata, lat);
        chk("drop_done", 64'(o_m0_done), 64'd1);
        chk("drop_latency", 64'(lat), 64'(LAT + 1));
        chk("drop_rdata", 64'(o_m0_rdata), 64'(model_mem[4]));
        repeat (8) tick();
        chk("drop_single_access", 64'(cnt_rd - r0), 64'(LAT));
        chk("drop_idle", 64'(o_busy), 64'd0);

        // Reset in the middle of a port-0 write; afterwards port 0 must win a tie
        m0_we = 1'b1; m0_addr = 32'h190; m0_wdata = 32'h1111_2222; m0_req = 1'b1;
        tick();
        chk("rst_mid_pre_wr", 64'(o_mem_wr), 64'd1);
        #2 i_reset = 1'b0;
        #1;
        $display("reset_mid wr=%0d busy=%0d done=%0d", o_mem_wr, o_busy, o_m0_done);
        chk("rst_mid_outputs", {o_mem_wr, o_busy, o_m0_done, o_m1_done}, 4'b0000);
        m0_req = 1'b0;
        tick(); tick();
        i_reset = 1'b1;
        m0_we = 1'b0; m0_addr = 32'h20; m1_we = 1'b0; m1_addr = 32'h24;
        m0_req = 1'b1; m1_req = 1'b1;
        first = -1;
        for (int t = 0; t < TIMEOUT && first < 0; t++) begin
            tick();
            if (o_m0_done) first = 0;
            else if (o_m1_done) first = 1;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        $display("post_reset tie first=%0d", first);
        chk("post_reset_tie", 64'(first), 64'd0);
        tick(); tick(); tick(); tick();

        // Randomized traffic on both ports against the reference contents
        f0 = 1'b0; f1 = 1'b0; ov0 = 0; ov1 = 0; guard = 0;
        fork
            begin
                for (int k = 0; k < NRAND; k++) rand_txn(1'b0);
                f0 = 1'b1;
            end
            begin
                for (int k = 0; k < NRAND; k++) rand_txn(1'b1);
                f1 = 1'b1;
            end
            begin
                while (!(f0 && f1) && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                    if (o_mem_rd && o_mem_wr) chk("rand_rd_wr_exclusive", 64'd1, 64'd0);
                    if (o_m0_done) begin
                        chk("rand_done0_requested", 64'(m0_req), 64'd1);
                        if (m1_req) ov1++;
                        ov0 = 0;
                        chk("rand_fair_p1", 64'(ov1 <= 1), 64'd1);
                    end
                    if (o_m1_done) begin
                        chk("rand_done1_requested", 64'(m1_req), 64'd1);
                        if (m0_req) ov0++;
                        ov1 = 0;
                        chk("rand_fair_p0", 64'(ov0 <= 1), 64'd1);
                    end
                end
            end
        join
        chk("rand_completed", 64'(f0 && f1), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
